// File: rtl/trig_pkg.sv
// Shared types and timing rules for the trigger pulse sequencer.
package trig_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } trig_state_e;

  localparam int TRIG_PULSE_WIDTH_DEF = 4;
  localparam int TRIG_MIN_STEP        = TRIG_PULSE_WIDTH_DEF + 1;

  // At least one low cycle must separate consecutive pulses.
  function automatic int trig_min_step(input int pulse_width);
    return pulse_width + 1;
  endfunction

endpackage

// File: rtl/trig_down_counter.sv
// Loadable down-counter with zero flag; times the DELAY, PULSE and GAP phases.
module trig_down_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       cnt_q <= '0;
    else if (load_i)                 cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_q <= cnt_q - ONE;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/trig_sequencer.sv
// Trigger pulse-train sequencer: optional start delay, then num pulses of
// PULSE_WIDTH cycles spaced by a clamped step, with abort and overrun report.
module trig_sequencer
  import trig_pkg::*;
#(
  parameter int PULSE_WIDTH = TRIG_PULSE_WIDTH_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_trig,
  input  logic [CNT_W-1:0] I_trig_num,
  input  logic [CNT_W-1:0] I_trig_step,
  input  logic [CNT_W-1:0] I_wait,
  input  logic             I_abort,
  output logic             O_trig_pulse,
  output logic [CNT_W-1:0] O_pulse_idx,
  output logic             O_busy,
  output logic             O_done,
  output logic             O_overrun
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PW_C     = CNT_W'(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] PW_M1    = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] MIN_STEP = CNT_W'(trig_min_step(PULSE_WIDTH));

  trig_state_e      state_q;
  logic [CNT_W-1:0] num_q, step_q, idx_q;
  logic             pulse_q, busy_q, done_q, ovr_q;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] step_eff;

  assign step_eff = (I_trig_step < MIN_STEP) ? MIN_STEP : I_trig_step;

  // Counter is loaded with (phase length - 1) on phase entry and the phase
  // ends in the cycle its zero flag is seen.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      S_IDLE: if (I_trig && !I_abort) begin
        cnt_load = 1'b1;
        cnt_val  = (I_wait != '0) ? I_wait - ONE : PW_M1;
      end
      S_DELAY, S_GAP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = PW_M1;
        end else cnt_dec = 1'b1;
      end
      S_PULSE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = step_q - PW_C - ONE;
        end else cnt_dec = 1'b1;
      end
      default: ;
    endcase
  end

  trig_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (I_clk),
    .rst_i      (I_rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovr_q  <= I_trig && (state_q != S_IDLE);
      if (I_abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (I_trig && !I_abort) begin
            num_q  <= I_trig_num;
            step_q <= step_eff;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (I_trig_num == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (I_wait != '0) begin
              state_q <= S_DELAY;
            end else begin
              state_q <= S_PULSE;
              pulse_q <= 1'b1;
            end
          end
          S_DELAY: if (cnt_zero) begin
            state_q <= S_PULSE;
            pulse_q <= 1'b1;
          end
          S_PULSE: if (cnt_zero) begin
            pulse_q <= 1'b0;
            if (idx_q == num_q - ONE) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else state_q <= S_GAP;
          end
          S_GAP: if (cnt_zero) begin
            state_q <= S_PULSE;
            pulse_q <= 1'b1;
            idx_q   <= idx_q + ONE;
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign O_trig_pulse = pulse_q;
  assign O_pulse_idx  = idx_q;
  assign O_busy       = busy_q;
  assign O_done       = done_q;
  assign O_overrun    = ovr_q;

endmodule
